rx_cmd_decoder: RTL and testbench
=================================

Name: rx_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its per-byte output: P_DATA, data_valid, parity_error and framing_error.
- Assembles multi-byte command frames and turns them into single-cycle register-file write/read strobes and ALU-start strobes for the system controller.
- Holds response-producing commands (read, ALU) until the transmit side reports it is not busy.
- Aborts a frame on line errors or an inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, width of the received byte and of WrData.
- ADDR_WIDTH, 4, register-file address width; the address byte is truncated to its low ADDR_WIDTH bits.
- TIMEOUT_WIDTH, 16, width of the inter-byte timeout counter and of the Timeout port.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  DATA_WIDTH  received byte, valid only while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- RX_PAR_ERR  in  1  receiver parity error.
- RX_FRM_ERR  in  1  receiver framing (stop-bit) error.
- Timeout  in  TIMEOUT_WIDTH  maximum idle cycles between bytes inside a frame; 0 disables the timeout.
- Rsp_Busy  in  1  high while the TX path cannot accept a new response.
- WrEn  out  1  register-file write strobe, one cycle.
- RdEn  out  1  register-file read strobe, one cycle.
- Address  out  ADDR_WIDTH  address for WrEn/RdEn.
- WrData  out  DATA_WIDTH  write data.
- ALU_EN  out  1  ALU start strobe, one cycle.
- ALU_FUN  out  4  ALU function, held stable from ALU_EN until the next ALU command.
- busy  out  1  high whenever the FSM is not in IDLE.
- cmd_err  out  1  one-cycle pulse for each rejected or aborted frame.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; internal latches 0; timeout counter 0.
- All outputs are registered. A byte sampled at edge N with RX_D_VLD=1 produces any resulting strobe in cycle N+1.
- Command opcodes, decoded in IDLE:
  - 0xAA: register write, frame = AA, addr, data.
  - 0xBB: register read, frame = BB, addr.
  - 0xCC: ALU with operands, frame = CC, opA, opB, fun.
  - 0xDD: ALU without operands, frame = DD, fun.
  - Any other byte: stay in IDLE and pulse cmd_err.
- FSM states and transitions:
  - IDLE: decode as above; AA→WR_ADDR, BB→RD_ADDR, CC→OPA, DD→FUN.
  - WR_ADDR: on byte, latch the address → WR_DATA.
  - WR_DATA: on byte, WrEn=1, Address=latched address, WrData=byte for one cycle → IDLE.
  - RD_ADDR: on byte, latch the address → RD_WAIT.
  - RD_WAIT: in any cycle with Rsp_Busy=0, RdEn=1 with Address in the next cycle → IDLE. Otherwise hold.
  - OPA: on byte, WrEn=1, Address=0, WrData=byte → OPB.
  - OPB: on byte, WrEn=1, Address=1, WrData=byte → FUN.
  - FUN: on byte, latch byte[3:0] as fun → ALU_WAIT.
  - ALU_WAIT: when Rsp_Busy=0, ALU_EN=1 and ALU_FUN=fun → IDLE.
- Line errors:
  - RX_PAR_ERR or RX_FRM_ERR high in any non-IDLE cycle: abort to IDLE, pulse cmd_err, issue no pending strobe.
  - In IDLE, line errors are ignored, and a byte whose RX_D_VLD coincides with an error is discarded.
- Bytes arriving in RD_WAIT or ALU_WAIT are dropped and pulse cmd_err; the state is unchanged.
- Timeout:
  - The counter runs only in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN (and CHK when the optional feature is enabled).
  - It clears on each accepted byte and on state entry.
  - When the count reaches Timeout (and Timeout≠0): go to IDLE and pulse cmd_err.
  - A byte arriving in the expiry cycle wins: the byte is accepted and the counter clears.
  - The counter saturates and never wraps.
- Strobes never overlap: at most one of WrEn, RdEn, ALU_EN is high in any cycle.
- RST asserted mid-frame returns to the reset state at the next edge; no strobe is issued.

Optional Feature:
- Macro RX_CMD_CHKSUM_EN.
- Defined:
  - Every frame carries one extra trailing byte, checked in state CHK after the last payload byte.
  - The trailing byte must equal the XOR of all prior frame bytes, opcode included.
  - All strobes of the frame, including the opA/opB writes, are deferred until after CHK. WrEn writes issue on consecutive cycles, addr 0 then addr 1, followed by ALU_WAIT.
  - On mismatch: return to IDLE, pulse cmd_err, issue no strobes.
- Undefined: no CHK state; behaviour exactly as above.

Test Plan:
- Bytes AA,05,3C → one WrEn cycle with Address=5, WrData=0x3C, the cycle after the 3C byte; busy low after.
- Bytes BB,0A with Rsp_Busy=1 for 20 cycles → RdEn held off; RdEn pulses once with Address=0xA one cycle after Rsp_Busy falls.
- Bytes CC,12,34,02 with Rsp_Busy=0 → WrEn pulses (addr0=0x12), (addr1=0x34), then ALU_EN with ALU_FUN=2.
- Timeout=100; bytes AA,03 then silence → 100 cycles later cmd_err pulses, state IDLE, no WrEn; a subsequent DD,01 gives ALU_EN with ALU_FUN=1.
- Bytes AA,04 then RX_PAR_ERR pulse → cmd_err, no WrEn; a stray byte 0x77 in IDLE → cmd_err only.
- With RX_CMD_CHKSUM_EN: bytes AA,05,3C,93 → WrEn executes; bytes AA,05,3C,00 → cmd_err, no WrEn.

Source files
------------

// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: assembles UART RX bytes into register-file and ALU command strobes.
// Define RX_CMD_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module rx_cmd_decoder #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     RX_PAR_ERR,
  input  logic                     RX_FRM_ERR,
  input  logic [TIMEOUT_WIDTH-1:0] Timeout,
  input  logic                     Rsp_Busy,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     busy,
  output logic                     cmd_err
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, CHK, ISS_OPB
  } state_t;

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hDD);

  state_t                   state_reg, state_next;
  logic [TIMEOUT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [TIMEOUT_WIDTH:0]   cnt_inc;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
  logic [3:0]               fun_reg, fun_next;
  logic                     wr_en_reg, wr_en_next;
  logic                     rd_en_reg, rd_en_next;
  logic                     alu_en_reg, alu_en_next;
  logic                     cmd_err_reg, cmd_err_next;
  logic                     busy_reg, busy_next;
  logic [ADDR_WIDTH-1:0]    address_reg, address_next;
  logic [DATA_WIDTH-1:0]    wr_data_reg, wr_data_next;
  logic [3:0]               alu_fun_reg, alu_fun_next;
  logic                     line_err, timed, expire;
`ifdef RX_CMD_CHKSUM_EN
  logic [DATA_WIDTH-1:0]    data_reg, data_next;
  logic [DATA_WIDTH-1:0]    opa_reg, opa_next;
  logic [DATA_WIDTH-1:0]    opb_reg, opb_next;
  logic [DATA_WIDTH-1:0]    chk_reg, chk_next;
  logic [DATA_WIDTH-1:0]    op_reg, op_next;
`endif

  assign line_err = RX_PAR_ERR | RX_FRM_ERR;
  assign cnt_inc  = {1'b0, cnt_reg} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
  assign expire   = timed && (Timeout != '0) && (cnt_inc >= {1'b0, Timeout});

  // Only states waiting on the next frame byte are subject to the inter-byte timeout.
  always_comb begin
    timed = 1'b0;
    case (state_reg)
      WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN: timed = 1'b1;
`ifdef RX_CMD_CHKSUM_EN
      CHK: timed = 1'b1;
`endif
      default: timed = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    addr_next    = addr_reg;
    fun_next     = fun_reg;
    wr_en_next   = 1'b0;
    rd_en_next   = 1'b0;
    alu_en_next  = 1'b0;
    cmd_err_next = 1'b0;
    address_next = address_reg;
    wr_data_next = wr_data_reg;
    alu_fun_next = alu_fun_reg;
`ifdef RX_CMD_CHKSUM_EN
    data_next = data_reg;
    opa_next  = opa_reg;
    opb_next  = opb_reg;
    chk_next  = chk_reg;
    op_next   = op_reg;
`endif
    if (state_reg == IDLE) begin
      if (RX_D_VLD && !line_err) begin
`ifdef RX_CMD_CHKSUM_EN
        chk_next = RX_P_DATA;
        op_next  = RX_P_DATA;
`endif
        case (RX_P_DATA)
          OP_WR:     state_next = WR_ADDR;
          OP_RD:     state_next = RD_ADDR;
          OP_ALU_OP: state_next = OPA;
          OP_ALU:    state_next = FUN;
          default:   cmd_err_next = 1'b1;
        endcase
      end
    end else if (line_err) begin
      state_next   = IDLE;
      cmd_err_next = 1'b1;
    end else if (timed && !RX_D_VLD) begin
      if (expire) begin
        state_next   = IDLE;
        cmd_err_next = 1'b1;
      end else if (cnt_reg != '1) begin
        cnt_next = cnt_inc[TIMEOUT_WIDTH-1:0];
      end
    end else begin
      // Timed states reach here only with a byte present; wait states every cycle.
`ifdef RX_CMD_CHKSUM_EN
      if (timed) chk_next = chk_reg ^ RX_P_DATA;
`endif
      case (state_reg)
        WR_ADDR: begin
          addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next = WR_DATA;
        end
        WR_DATA: begin
`ifdef RX_CMD_CHKSUM_EN
          data_next  = RX_P_DATA;
          state_next = CHK;
`else
          wr_en_next   = 1'b1;
          address_next = addr_reg;
          wr_data_next = RX_P_DATA;
          state_next   = IDLE;
`endif
        end
        RD_ADDR: begin
          addr_next = RX_P_DATA[ADDR_WIDTH-1:0];
`ifdef RX_CMD_CHKSUM_EN
          state_next = CHK;
`else
          state_next = RD_WAIT;
`endif
        end
        OPA: begin
`ifdef RX_CMD_CHKSUM_EN
          opa_next = RX_P_DATA;
`else
          wr_en_next   = 1'b1;
          address_next = '0;
          wr_data_next = RX_P_DATA;
`endif
          state_next = OPB;
        end
        OPB: begin
`ifdef RX_CMD_CHKSUM_EN
          opb_next = RX_P_DATA;
`else
          wr_en_next   = 1'b1;
          address_next = ADDR_WIDTH'(1);
          wr_data_next = RX_P_DATA;
`endif
          state_next = FUN;
        end
        FUN: begin
          fun_next = RX_P_DATA[3:0];
`ifdef RX_CMD_CHKSUM_EN
          state_next = CHK;
`else
          state_next = ALU_WAIT;
`endif
        end
        RD_WAIT: begin
          if (RX_D_VLD) begin
            cmd_err_next = 1'b1;
          end else if (!Rsp_Busy) begin
            rd_en_next   = 1'b1;
            address_next = addr_reg;
            state_next   = IDLE;
          end
        end
        ALU_WAIT: begin
          if (RX_D_VLD) begin
            cmd_err_next = 1'b1;
          end else if (!Rsp_Busy) begin
            alu_en_next  = 1'b1;
            alu_fun_next = fun_reg;
            state_next   = IDLE;
          end
        end
`ifdef RX_CMD_CHKSUM_EN
        CHK: begin
          if (RX_P_DATA != chk_reg) begin
            cmd_err_next = 1'b1;
            state_next   = IDLE;
          end else begin
            case (op_reg)
              OP_WR: begin
                wr_en_next   = 1'b1;
                address_next = addr_reg;
                wr_data_next = data_reg;
                state_next   = IDLE;
              end
              OP_RD: state_next = RD_WAIT;
              OP_ALU_OP: begin
                wr_en_next   = 1'b1;
                address_next = '0;
                wr_data_next = opa_reg;
                state_next   = ISS_OPB;
              end
              default: state_next = ALU_WAIT;
            endcase
          end
        end
        ISS_OPB: begin
          wr_en_next   = 1'b1;
          address_next = ADDR_WIDTH'(1);
          wr_data_next = opb_reg;
          state_next   = ALU_WAIT;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      fun_reg     <= '0;
      wr_en_reg   <= 1'b0;
      rd_en_reg   <= 1'b0;
      alu_en_reg  <= 1'b0;
      cmd_err_reg <= 1'b0;
      busy_reg    <= 1'b0;
      address_reg <= '0;
      wr_data_reg <= '0;
      alu_fun_reg <= '0;
`ifdef RX_CMD_CHKSUM_EN
      data_reg <= '0;
      opa_reg  <= '0;
      opb_reg  <= '0;
      chk_reg  <= '0;
      op_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      fun_reg     <= fun_next;
      wr_en_reg   <= wr_en_next;
      rd_en_reg   <= rd_en_next;
      alu_en_reg  <= alu_en_next;
      cmd_err_reg <= cmd_err_next;
      busy_reg    <= busy_next;
      address_reg <= address_next;
      wr_data_reg <= wr_data_next;
      alu_fun_reg <= alu_fun_next;
`ifdef RX_CMD_CHKSUM_EN
      data_reg <= data_next;
      opa_reg  <= opa_next;
      opb_reg  <= opb_next;
      chk_reg  <= chk_next;
      op_reg   <= op_next;
`endif
    end
  end

  assign WrEn    = wr_en_reg;
  assign RdEn    = rd_en_reg;
  assign ALU_EN  = alu_en_reg;
  assign cmd_err = cmd_err_reg;
  assign busy    = busy_reg;
  assign Address = address_reg;
  assign WrData  = wr_data_reg;
  assign ALU_FUN = alu_fun_reg;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Testbench for rx_cmd_decoder: directed frames plus random byte streams checked
// against a frame-queue reference model.
module tb_rx_cmd_decoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD, RX_PAR_ERR, RX_FRM_ERR, Rsp_Busy;
  logic [15:0] Timeout;
  logic        WrEn, RdEn, ALU_EN, busy, cmd_err;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData;

  int checks = 0;
  int errors = 0;

  rx_cmd_decoder dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_FRM_ERR(RX_FRM_ERR), .Timeout(Timeout),
    .Rsp_Busy(Rsp_Busy), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .busy(busy),
    .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the bytes of the frame in progress and whether it awaits Rsp_Busy.
  byte unsigned m_q[$];
  bit           m_pend;
  int           m_idle;
  bit           e_wr, e_rd, e_alu, e_err, e_busy;
  logic [3:0]   e_addr, e_fun;
  logic [7:0]   e_wdata;

  function automatic int frame_len(input byte unsigned op);
    case (op)
      8'hAA: return 3;
      8'hBB: return 2;
      8'hCC: return 4;
      8'hDD: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pend = 0; m_idle = 0;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0; e_busy = 0;
    e_addr = 0; e_fun = 0; e_wdata = 0;
  endfunction

  function automatic void model_step(input bit vld, input byte unsigned d, input bit pe,
                                     input bit fe, input bit rb, input int tmo);
    int n;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (m_q.size() == 0) begin
      if (vld && !pe && !fe) begin
        if (frame_len(d) != 0) begin m_q.push_back(d); m_idle = 0; end
        else e_err = 1;
      end
    end else if (pe || fe) begin
      m_q.delete(); m_pend = 0; e_err = 1;
    end else if (m_pend) begin
      if (vld) e_err = 1;
      else if (!rb) begin
        if (m_q[0] == 8'hBB) begin e_rd = 1; e_addr = m_q[1][3:0]; end
        else begin e_alu = 1; e_fun = m_q[m_q.size()-1][3:0]; end
        m_q.delete(); m_pend = 0;
      end
    end else if (vld) begin
      m_q.push_back(d); m_idle = 0;
      n = m_q.size();
      if (m_q[0] == 8'hCC && (n == 2 || n == 3)) begin
        e_wr = 1; e_addr = 4'(n - 2); e_wdata = d;
      end
      if (n == frame_len(m_q[0])) begin
        if (m_q[0] == 8'hAA) begin
          e_wr = 1; e_addr = m_q[1][3:0]; e_wdata = d;
          m_q.delete();
        end else m_pend = 1;
      end
    end else begin
      m_idle++;
      if (tmo != 0 && m_idle >= tmo) begin m_q.delete(); e_err = 1; end
    end
    e_busy = (m_q.size() != 0);
  endfunction

  task automatic drive_cycle(input bit vld, input byte unsigned d, input bit pe,
                             input bit fe, input bit rb);
    @(negedge CLK);
    RX_D_VLD = vld; RX_P_DATA = d; RX_PAR_ERR = pe; RX_FRM_ERR = fe; Rsp_Busy = rb;
    model_step(vld, d, pe, fe, rb, int'(Timeout));
    @(posedge CLK);
    #1;
    check_eq("wren", WrEn, e_wr);
    check_eq("rden", RdEn, e_rd);
    check_eq("alu_en", ALU_EN, e_alu);
    check_eq("cmd_err", cmd_err, e_err);
    check_eq("busy", busy, e_busy);
    check_eq("alu_fun", ALU_FUN, e_fun);
    if (e_wr) begin
      check_eq("wr_addr", Address, e_addr);
      check_eq("wr_data", WrData, e_wdata);
      $display("txn t=%0t WR addr=%0h data=%02h", $time, e_addr, e_wdata);
    end
    if (e_rd) begin
      check_eq("rd_addr", Address, e_addr);
      $display("txn t=%0t RD addr=%0h", $time, e_addr);
    end
    if (e_alu) $display("txn t=%0t ALU fun=%0h", $time, e_fun);
    if (e_err) $display("txn t=%0t CMD_ERR", $time);
  endtask

  task automatic send(input byte unsigned d, input bit rb);
    drive_cycle(1'b1, d, 1'b0, 1'b0, rb);
  endtask

  task automatic idle(input int n, input bit rb);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, rb);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_FRM_ERR = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    check_eq("rst_wren", WrEn, 1'b0);
    check_eq("rst_rden", RdEn, 1'b0);
    check_eq("rst_alu_en", ALU_EN, 1'b0);
    check_eq("rst_cmd_err", cmd_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_address", Address, 4'h0);
    check_eq("rst_wrdata", WrData, 8'h00);
    check_eq("rst_alu_fun", ALU_FUN, 4'h0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

`ifdef RX_CMD_CHKSUM_EN
  int wr_cnt, err_cnt;
  logic [3:0] last_addr;
  logic [7:0] last_data;

  task automatic raw_frame(input byte unsigned b0, input byte unsigned b1,
                           input byte unsigned b2, input byte unsigned b3);
    byte unsigned fb[4];
    fb = '{b0, b1, b2, b3};
    wr_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      RX_D_VLD = (i < 4); RX_P_DATA = (i < 4) ? fb[i] : 8'h00;
      @(posedge CLK);
      #1;
      if (WrEn) begin wr_cnt++; last_addr = Address; last_data = WrData; end
      if (cmd_err) err_cnt++;
    end
    $display("txn t=%0t frame %02h %02h %02h %02h wr=%0d err=%0d", $time, b0, b1, b2, b3, wr_cnt, err_cnt);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    byte unsigned ops[4];
    bit rb, v, pe, fe;
    byte unsigned d;
    ops = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    RST = 1'b1; RX_P_DATA = 0; RX_D_VLD = 0; RX_PAR_ERR = 0; RX_FRM_ERR = 0;
    Rsp_Busy = 0; Timeout = 16'd0;
    apply_reset();

`ifdef RX_CMD_CHKSUM_EN
    raw_frame(8'hAA, 8'h05, 8'h3C, 8'h93);
    check_eq("chk_ok_wr", wr_cnt, 1);
    check_eq("chk_ok_err", err_cnt, 0);
    check_eq("chk_ok_addr", last_addr, 4'h5);
    check_eq("chk_ok_data", last_data, 8'h3C);
    raw_frame(8'hAA, 8'h05, 8'h3C, 8'h00);
    check_eq("chk_bad_wr", wr_cnt, 0);
    check_eq("chk_bad_err", err_cnt, 1);
`else
    // Directed frames
    send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0); idle(2, 0);
    send(8'hBB, 1); send(8'h0A, 1); idle(20, 1); idle(3, 0);
    send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h02, 0); idle(3, 0);
    Timeout = 16'd100;
    send(8'hAA, 0); send(8'h03, 0); idle(105, 0);
    send(8'hDD, 0); send(8'h01, 0); idle(2, 0);
    send(8'hAA, 0); send(8'h04, 0);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 0);
    send(8'h77, 0); idle(2, 0);
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b1, 0); idle(2, 0);
    send(8'hBB, 1); send(8'h03, 1); send(8'h55, 1); idle(2, 1); idle(2, 0);
    Timeout = 16'd5;
    send(8'hAA, 0); idle(4, 0); send(8'h09, 0); idle(4, 0); send(8'hE1, 0); idle(2, 0);
    send(8'hAA, 0); send(8'h06, 0); idle(6, 0);
    Timeout = 16'd0;
    send(8'hDD, 0); idle(200, 0); send(8'h0F, 0); idle(2, 0);
    send(8'hAA, 0); send(8'h05, 0);
    apply_reset();
    idle(3, 0);

    // Random byte streams
    Timeout = 16'd12;
    rb = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) rb = ~rb;
      v  = ($urandom_range(0, 99) < 35);
      if (m_q.size() == 0 && $urandom_range(0, 9) != 0) d = ops[$urandom_range(0, 3)];
      else d = 8'($urandom_range(0, 255));
      pe = ($urandom_range(0, 99) < 2);
      fe = ($urandom_range(0, 99) == 0);
      drive_cycle(v, d, pe, fe, rb);
      if ($urandom_range(0, 149) == 0) idle(15, rb);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
